rotate_unit: RTL

Consumer stage for the sine/cosine lookup table. It accepts a point (x, y) and an angle in degrees over a valid/ready handshake, reduces the angle to [0,359], and reads sine and then cosine from the external combinational LUT through a shared port, one per cycle. It then rotates the point in fixed point and returns (x', y') over a valid/ready handshake. It sits between the command/decoder logic and the pixel/coordinate writeback path of the image-rotation datapath.

---
 rtl/rot_pkg.sv | 21 ++
 rtl/rot_mac.sv | 55 +++++
 rtl/rotate_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/rot_pkg.sv
// Shared types and constants for the point-rotation datapath
// and the sine/cosine LUT op-select encodings.
package rot_pkg;

    localparam int DEG_360 = 360;
    localparam int FRAC_W  = 16;
    localparam int COORD_W = 16;

    localparam logic OP_SIN = 1'b0;
    localparam logic OP_COS = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        SIN,
        COS,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/rot_mac.sv
// Two-product sum a*p +/- b*q with round-half-up and
// saturation to a signed COORD_W result.
module rot_mac #(
    parameter int COORD_W = 16,
    parameter int FRAC_W  = 16
) (
    input  logic signed [COORD_W-1:0] a,
    input  logic signed [COORD_W-1:0] b,
    input  logic signed [31:0]        p,
    input  logic signed [31:0]        q,
    input  logic                      sub,
    output logic signed [COORD_W-1:0] res,
    output logic                      sat
);

    localparam int PW = COORD_W + 32;
    localparam int SW = PW + 1;
    localparam int RW = SW - FRAC_W;

    localparam logic signed [SW-1:0] HALF =
        {{(SW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [RW-1:0] HI =
        {{(RW-COORD_W+1){1'b0}}, {(COORD_W-1){1'b1}}};
    localparam logic signed [RW-1:0] LO =
        {{(RW-COORD_W+1){1'b1}}, {(COORD_W-1){1'b0}}};

    logic signed [PW-1:0] ae, be, pe, qe;
    logic signed [PW-1:0] pa, pb;
    logic signed [SW-1:0] sum, rnd;
    logic signed [RW-1:0] shr;

    assign ae  = PW'(a);
    assign be  = PW'(b);
    assign pe  = PW'(p);
    assign qe  = PW'(q);
    assign pa  = ae * pe;
    assign pb  = be * qe;
    assign sum = sub ? (SW'(pa) - SW'(pb)) : (SW'(pa) + SW'(pb));
    assign rnd = sum + HALF;
    // taking the upper bits is the arithmetic shift right by FRAC_W
    assign shr = rnd[SW-1:FRAC_W];

    always_comb begin
        res = shr[COORD_W-1:0];
        sat = 1'b0;
        if (shr > HI) begin
            res = {1'b0, {(COORD_W-1){1'b1}}};
            sat = 1'b1;
        end else if (shr < LO) begin
            res = {1'b1, {(COORD_W-1){1'b0}}};
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/rotate_unit.sv
// Rotates (x, y) by an angle in degrees using sine/cosine read
// one per cycle from a shared external combinational LUT port.
module rotate_unit #(
    parameter int COORD_W = rot_pkg::COORD_W,
    parameter int FRAC_W  = rot_pkg::FRAC_W,
    parameter int ANG_W   = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] in_x,
    input  logic signed [COORD_W-1:0] in_y,
    input  logic [ANG_W-1:0]          in_angle,
    output logic                      lut_op_sel,
    output logic [31:0]               lut_angle,
    input  logic signed [31:0]        lut_value,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [COORD_W-1:0] out_x,
    output logic signed [COORD_W-1:0] out_y,
    output logic                      out_sat,
    output logic                      busy
);

    import rot_pkg::*;

    state_t                    state;
    logic signed [COORD_W-1:0] x, y;
    logic [10:0]               ang;
    logic signed [31:0]        s, c;
    logic signed [COORD_W-1:0] nx, ny;
    logic                      sx, sy;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // LUT port driven from registered state only
    assign lut_op_sel = (state == COS) ? OP_COS : OP_SIN;
    assign lut_angle  = (state == SIN || state == COS) ? 32'(ang) : 32'd0;

    rot_mac #(.COORD_W(COORD_W), .FRAC_W(FRAC_W)) u_mac_x (
        .a(x), .b(y), .p(c), .q(s), .sub(1'b1), .res(nx), .sat(sx)
    );

    rot_mac #(.COORD_W(COORD_W), .FRAC_W(FRAC_W)) u_mac_y (
        .a(x), .b(y), .p(s), .q(c), .sub(1'b0), .res(ny), .sat(sy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            ang     <= '0;
            s       <= '0;
            c       <= '0;
            out_x   <= '0;
            out_y   <= '0;
            out_sat <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x     <= in_x;
                        y     <= in_y;
                        ang   <= 11'(in_angle);
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (ang >= 11'(DEG_360)) ang <= ang - 11'(DEG_360);
                    else                     state <= SIN;
                end
                SIN: begin
                    s     <= lut_value;
                    state <= COS;
                end
                COS: begin
                    c     <= lut_value;
                    state <= MUL;
                end
                MUL: begin
                    out_x   <= nx;
                    out_y   <= ny;
                    out_sat <= sx | sy;
                    state   <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
